// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin share of the register-file write port between ALU and MEM writeback, plus pending-write scoreboard.
// Latency: request accepted in cycle N drives write_enable/addr/data during cycle N+1; busy updates at the same edge.
// Backpressure: ready is combinational from valid and last grant; at most one ready per cycle, loser waits at most one cycle.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  nRESET,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e                last_grant;
    logic                  alu_xfer;
    logic                  mem_xfer;
    logic [NUM_REGS-1:0]   clr_mask;
    logic [NUM_REGS-1:0]   set_mask;

    // Grant: a lone requester always wins; on a tie the one not granted last time wins.
    always_comb begin
        alu_ready = alu_valid && (!mem_valid || (last_grant == GRANT_MEM));
        mem_ready = mem_valid && (!alu_valid || (last_grant == GRANT_ALU));
        alu_xfer  = alu_valid && alu_ready;
        mem_xfer  = mem_valid && mem_ready;
    end

    // Remember the most recent winner; reset to MEM so the first tie goes to ALU.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            last_grant <= GRANT_MEM;
        end else if (alu_xfer) begin
            last_grant <= GRANT_ALU;
        end else if (mem_xfer) begin
            last_grant <= GRANT_MEM;
        end
    end

    // Register the winner onto the write port; address/data hold when idle.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= alu_xfer || mem_xfer;
            if (alu_xfer) begin
                write_addr <= alu_addr;
                write_data <= alu_data;
            end else if (mem_xfer) begin
                write_addr <= mem_addr;
                write_data <= mem_data;
            end
        end
    end

    // Scoreboard masks: a transfer retires its destination, an issue marks a new pending writer.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (alu_xfer) begin
            clr_mask[alu_addr] = 1'b1;
        end
        if (mem_xfer) begin
            clr_mask[mem_addr] = 1'b1;
        end
        if (issue_valid) begin
            set_mask[issue_addr] = 1'b1;
        end
    end

    // Apply set after clear so a newer writer on the same register keeps it busy.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed checks of regfile_wb_arbiter arbitration, write port and scoreboard.
// Latency: sequence of directed steps, outputs sampled 1 time unit after the rising edge.
// Backpressure: requesters hold valid/addr/data until ready, as a real requester would.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        nRESET;
    logic        alu_valid;
    logic [2:0]  alu_addr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [2:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [2:0]  issue_addr;
    logic [7:0]  busy;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3),
        .NUM_REGS(8)
    ) dut (
        .clk(clk),
        .nRESET(nRESET),
        .alu_valid(alu_valid),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .issue_valid(issue_valid),
        .issue_addr(issue_addr),
        .busy(busy),
        .write_enable(write_enable),
        .write_addr(write_addr),
        .write_data(write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic we, input logic [2:0] wa, input logic [15:0] wd);
        check({tag, "_we"}, {31'd0, write_enable}, {31'd0, we});
        check({tag, "_wa"}, {29'd0, write_addr}, {29'd0, wa});
        check({tag, "_wd"}, {16'd0, write_data}, {16'd0, wd});
    endtask

    task automatic check_ready(input string tag, input logic ar, input logic mr);
        check({tag, "_alu_ready"}, {31'd0, alu_ready}, {31'd0, ar});
        check({tag, "_mem_ready"}, {31'd0, mem_ready}, {31'd0, mr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRESET      = 1'b0;
        alu_valid   = 1'b0;
        alu_addr    = '0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_addr    = '0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        repeat (2) tick();
        nRESET = 1'b1;
        #1;
        check_port("reset", 1'b0, 3'd0, 16'h0000);
        check("reset_busy", {24'd0, busy}, 32'h00);
        check_ready("reset_idle", 1'b0, 1'b0);

        // Prime write port with a lone ALU write to 6.
        alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h00AA;
        #1;
        check_ready("lone_alu", 1'b1, 1'b0);
        tick();
        alu_valid = 1'b0;
        check_port("lone_alu_wr", 1'b1, 3'd6, 16'h00AA);

        // Fill the scoreboard.
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue_addr = 3'(i);
            tick();
        end
        issue_valid = 1'b0;
        check("busy_full", {24'd0, busy}, 32'hFF);
        check_port("busy_full_port", 1'b0, 3'd6, 16'h00AA);

        // Asynchronous reset between edges with ALU request held.
        alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h5555;
        #2;
        nRESET = 1'b0;
        #1;
        check("async_busy", {24'd0, busy}, 32'h00);
        check_port("async_port", 1'b0, 3'd0, 16'h0000);
        tick();
        nRESET = 1'b1;

        // First tie after reset goes to ALU; MEM is served next cycle.
        mem_valid = 1'b1; mem_addr = 3'd4; mem_data = 16'h4444;
        #1;
        check_ready("first_tie", 1'b1, 1'b0);
        tick();
        alu_valid = 1'b0;
        check_port("first_tie_wr", 1'b1, 3'd2, 16'h5555);
        #1;
        check_ready("held_mem", 1'b0, 1'b1);
        tick();
        mem_valid = 1'b0;
        check_port("held_mem_wr", 1'b1, 3'd4, 16'h4444);
        check("nonbusy_wr_busy", {24'd0, busy}, 32'h00);

        // Single ALU write retires a pending register.
        issue_valid = 1'b1; issue_addr = 3'd3;
        tick();
        issue_valid = 1'b0;
        check("issue3_busy", {24'd0, busy}, 32'h08);
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 16'hBEEF;
        #1;
        check_ready("alu3", 1'b1, 1'b0);
        tick();
        alu_valid = 1'b0;
        check_port("alu3_wr", 1'b1, 3'd3, 16'hBEEF);
        check("alu3_busy", {24'd0, busy}, 32'h00);

        // Contention after reset: ALU, MEM, ALU, MEM.
        nRESET = 1'b0;
        tick();
        nRESET = 1'b1;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 16'h0011;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 16'h0022;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_ready($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
            check($sformatf("rr%0d_exclusive", k), {31'd0, alu_ready & mem_ready}, 32'd0);
            tick();
            if ((k % 2) == 0) check_port($sformatf("rr%0d_wr", k), 1'b1, 3'd1, 16'h0011);
            else              check_port($sformatf("rr%0d_wr", k), 1'b1, 3'd2, 16'h0022);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;

        // Same-address set and clear: set wins.
        issue_valid = 1'b1; issue_addr = 3'd5;
        tick();
        check("issue5_busy", {24'd0, busy}, 32'h20);
        mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h0555;
        #1;
        check_ready("collide", 1'b0, 1'b1);
        tick();
        check_port("collide_wr", 1'b1, 3'd5, 16'h0555);
        check("collide_busy", {24'd0, busy}, 32'h20);

        // Different-address set and clear: both apply.
        mem_data = 16'h0556; issue_addr = 3'd7;
        tick();
        issue_valid = 1'b0;
        mem_valid   = 1'b0;
        check_port("diff_wr", 1'b1, 3'd5, 16'h0556);
        check("diff_busy", {24'd0, busy}, 32'h80);

        // Idle hold after a write to 6.
        alu_valid = 1'b1; alu_addr = 3'd6; alu_data = 16'h1234;
        tick();
        alu_valid = 1'b0;
        check_port("idle_wr", 1'b1, 3'd6, 16'h1234);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_ready($sformatf("idle%0d", k), 1'b0, 1'b0);
            tick();
            check_port($sformatf("idle%0d_hold", k), 1'b0, 3'd6, 16'h1234);
        end
        check("idle_busy", {24'd0, busy}, 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
